// File: rtl/dcache_pkg.sv
// Shared types and address-split constants for the direct-mapped write-through data cache.
package dcache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_NUM_LINES      = 16;
    localparam int DEF_WORDS_PER_LINE = 4;

    // OFFSET_BITS covers both the byte offset and the word-in-line offset.
    localparam int OFFSET_BITS = 2 + $clog2(DEF_WORDS_PER_LINE);
    localparam int INDEX_BITS  = $clog2(DEF_NUM_LINES);
    localparam int TAG_BITS    = DEF_ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;

    localparam logic MEMTYPE_WORD = 1'b0;
    localparam logic MEMTYPE_BYTE = 1'b1;

endpackage

// File: rtl/dcache_refill_fsm.sv
// Line-refill sequencer: latches the missing line number and walks its words one per cycle.
module dcache_refill_fsm
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4,
    parameter int CNT_W          = 2,
    parameter int LINE_W         = 28
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [LINE_W-1:0]     i_line,
    output logic                  o_refill,
    output logic                  o_last,
    output logic [CNT_W-1:0]      o_cnt,
    output logic [LINE_W-1:0]     o_line,
    output logic [ADDR_WIDTH-1:0] o_fill_addr
);

    state_e            r_state;
    state_e            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [LINE_W-1:0] r_line;

    assign o_refill    = (r_state == REFILL);
    assign o_last      = (r_cnt == CNT_W'(WORDS_PER_LINE - 1));
    assign o_cnt       = r_cnt;
    assign o_line      = r_line;
    assign o_fill_addr = {r_line, r_cnt, 2'b00};

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_next = REFILL;
            REFILL:  if (o_last)  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_line  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (i_start) r_line <= i_line;
            end else begin
                r_cnt <= o_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_direct.sv
// Direct-mapped, write-through, no-write-allocate data cache between the memory stage and data memory.
module dcache_direct
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NUM_LINES      = DEF_NUM_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    input  logic                  i_req_we,
    input  logic                  i_req_memtype,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic [DATA_WIDTH-1:0] o_req_rdata,
    output logic                  o_stall,
    output logic                  o_mem_we,
    output logic                  o_mem_memtype,
    output logic [ADDR_WIDTH-1:0] o_mem_a,
    output logic [DATA_WIDTH-1:0] o_mem_wd,
    input  logic [DATA_WIDTH-1:0] i_mem_rd
);

    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = WSEL_W + 2;
    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int LINE_W = TAG_W + IDX_W;

    logic [NUM_LINES-1:0]                                 r_valid;
    logic [NUM_LINES-1:0][TAG_W-1:0]                      r_tag;
    logic [NUM_LINES-1:0][WORDS_PER_LINE-1:0][DATA_WIDTH-1:0] r_data;

    logic [TAG_W-1:0]      w_tag;
    logic [IDX_W-1:0]      w_idx;
    logic [WSEL_W-1:0]     w_wsel;
    logic [1:0]            w_boff;
    logic                  w_misal;
    logic                  w_hit;
    logic                  w_load_miss;
    logic [DATA_WIDTH-1:0] w_hit_word;
    logic [7:0]            w_hit_byte;

    logic                  w_refill;
    logic                  w_last;
    logic [WSEL_W-1:0]     w_cnt;
    logic [LINE_W-1:0]     w_fill_line;
    logic [ADDR_WIDTH-1:0] w_fill_addr;
    logic [IDX_W-1:0]      w_fill_idx;
    logic [TAG_W-1:0]      w_fill_tag;

    assign w_tag   = i_req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_idx   = i_req_addr[OFF_W +: IDX_W];
    assign w_wsel  = i_req_addr[2 +: WSEL_W];
    assign w_boff  = i_req_addr[1:0];
    assign w_misal = (i_req_memtype == MEMTYPE_WORD) && (w_boff != 2'b00);
    assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Misaligned words never allocate; they bypass the arrays entirely.
    assign w_load_miss = i_req_valid && !w_refill && !i_req_we && !w_misal && !w_hit;

    assign w_hit_word = r_data[w_idx][w_wsel];
    assign w_hit_byte = w_hit_word[{w_boff, 3'b000} +: 8];

    assign w_fill_idx = w_fill_line[IDX_W-1:0];
    assign w_fill_tag = w_fill_line[IDX_W +: TAG_W];

    dcache_refill_fsm #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .CNT_W          (WSEL_W),
        .LINE_W         (LINE_W)
    ) u_refill (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (w_load_miss),
        .i_line      ({w_tag, w_idx}),
        .o_refill    (w_refill),
        .o_last      (w_last),
        .o_cnt       (w_cnt),
        .o_line      (w_fill_line),
        .o_fill_addr (w_fill_addr)
    );

    always_comb begin
        o_req_rdata   = '0;
        o_stall       = 1'b0;
        o_mem_we      = 1'b0;
        o_mem_memtype = MEMTYPE_WORD;
        o_mem_a       = '0;
        o_mem_wd      = '0;
        if (i_rst_n) begin
            if (w_refill) begin
                o_stall = 1'b1;
                o_mem_a = w_fill_addr;
            end else if (i_req_valid) begin
                o_mem_a       = i_req_addr;
                o_mem_memtype = i_req_memtype;
                if (i_req_we) begin
                    o_mem_we = 1'b1;
                    o_mem_wd = i_req_wdata;
                end else if (w_misal) begin
                    o_req_rdata = i_mem_rd;
                end else if (w_hit) begin
                    o_req_rdata = (i_req_memtype == MEMTYPE_BYTE) ? DATA_WIDTH'(w_hit_byte) : w_hit_word;
                end else begin
                    o_stall = 1'b1;
                end
            end
        end
    end

    // The target line is invalidated at refill start so a half-filled line can never hit.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (w_refill) begin
            r_data[w_fill_idx][w_cnt] <= i_mem_rd;
            if (w_last) begin
                r_valid[w_fill_idx] <= 1'b1;
                r_tag[w_fill_idx]   <= w_fill_tag;
            end
        end else if (i_req_valid) begin
            if (w_misal || w_load_miss) begin
                r_valid[w_idx] <= 1'b0;
            end else if (i_req_we && w_hit) begin
                if (i_req_memtype == MEMTYPE_BYTE)
                    r_data[w_idx][w_wsel][{w_boff, 3'b000} +: 8] <= i_req_wdata[7:0];
                else
                    r_data[w_idx][w_wsel] <= i_req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_dcache_direct.sv
// Scoreboard bench: expected load data comes from a flat byte-array memory model, stall lengths from a tag-only cache model.
module tb_dcache_direct;
    import dcache_pkg::*;

    localparam int NL  = DEF_NUM_LINES;
    localparam int WPL = DEF_WORDS_PER_LINE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, req_memtype = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [31:0] req_rdata, mem_a, mem_wd, mem_rd;
    logic        stall, mem_we, mem_memtype;

    always #5 clk = ~clk;

    dcache_direct dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .i_req_we      (req_we),
        .i_req_memtype (req_memtype),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_req_rdata   (req_rdata),
        .o_stall       (stall),
        .o_mem_we      (mem_we),
        .o_mem_memtype (mem_memtype),
        .o_mem_a       (mem_a),
        .o_mem_wd      (mem_wd),
        .i_mem_rd      (mem_rd)
    );

    function automatic logic [7:0] init_byte(int i);
        case (i)
            0: return 8'hEF;
            1: return 8'hBE;
            2: return 8'hAD;
            3: return 8'hDE;
            256, 257, 258, 259: return 8'h00;
            default: return 8'(i * 37 + (i >> 8) * 11 + 5);
        endcase
    endfunction

    // Physical data memory, little-endian, addressed modulo 64 KiB.
    logic [7:0] dmem [0:65535];
    logic       init_done = 1'b0;
    assign mem_rd = {dmem[16'(mem_a + 32'd3)], dmem[16'(mem_a + 32'd2)],
                     dmem[16'(mem_a + 32'd1)], dmem[16'(mem_a)]};

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 65536; i++) dmem[i] <= init_byte(i);
            init_done <= 1'b1;
        end else if (mem_we) begin
            if (mem_memtype) dmem[mem_a[15:0]] <= mem_wd[7:0];
            else for (int i = 0; i < 4; i++) dmem[16'(mem_a + 32'(i))] <= mem_wd[8*i +: 8];
        end
    end

    // Reference model: what memory should hold, and which line tags the cache should hold.
    logic [7:0]          ref_mem [0:65535];
    logic                rv [NL];
    logic [TAG_BITS-1:0] rt [NL];

    typedef struct {
        logic        we;
        logic        mt;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        int          stalls;
    } exp_t;
    exp_t sbq[$];

    int n_chk = 0, n_fail = 0;
    int scnt = 0;
    logic done = 1'b0, drained = 1'b0;
    exp_t mon_e;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp_v, $time);
        end
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] a, logic mt);
        if (mt) return {24'h0, ref_mem[a[15:0]]};
        return {ref_mem[16'(a + 32'd3)], ref_mem[16'(a + 32'd2)], ref_mem[16'(a + 32'd1)], ref_mem[a[15:0]]};
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic mt, input logic [31:0] wd);
        if (mt) ref_mem[a[15:0]] = wd[7:0];
        else for (int i = 0; i < 4; i++) ref_mem[16'(a + 32'(i))] = wd[8*i +: 8];
    endtask

    task automatic model_access(input logic [31:0] a, input logic we, input logic mt, output int st);
        int idx;
        logic [TAG_BITS-1:0] tag;
        idx = int'((a >> OFFSET_BITS) % NL);
        tag = TAG_BITS'(a >> (OFFSET_BITS + INDEX_BITS));
        st  = 0;
        if (!mt && a[1:0] != 2'b00) rv[idx] = 1'b0;
        else if (!we && !(rv[idx] && rt[idx] == tag)) begin
            rv[idx] = 1'b1;
            rt[idx] = tag;
            st = WPL + 1;
        end
    endtask

    task automatic issue(input logic we, input logic mt, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int st;
        model_access(a, we, mt, st);
        e.we = we; e.mt = mt; e.addr = a; e.wd = wd; e.stalls = st;
        e.rd = we ? 32'h0 : ref_load(a, mt);
        if (we) ref_store(a, mt, wd);
        sbq.push_back(e);
        req_valid = 1'b1; req_we = we; req_memtype = mt; req_addr = a; req_wdata = wd;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (!stall) break;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Monitor: all comparisons happen here, at the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_stall", 32'(stall), 32'h0);
            chk("rst_mem_we", 32'(mem_we), 32'h0);
            chk("rst_mem_a", mem_a, 32'h0);
            chk("rst_mem_wd", mem_wd, 32'h0);
            chk("rst_memtype", 32'(mem_memtype), 32'h0);
            chk("rst_rdata", req_rdata, 32'h0);
            scnt = 0;
        end else if (!req_valid) begin
            chk("idle_stall", 32'(stall), 32'h0);
            chk("idle_mem_we", 32'(mem_we), 32'h0);
            chk("idle_rdata", req_rdata, 32'h0);
            scnt = 0;
        end else if (stall) begin
            if (scnt > 0) begin
                chk("refill_mem_a", mem_a, (req_addr & ~((32'd1 << OFFSET_BITS) - 32'd1)) + 32'(4 * (scnt - 1)));
                chk("refill_mem_we", 32'(mem_we), 32'h0);
            end
            scnt++;
            chk("stall_len", 32'(scnt > WPL + 1), 32'h0);
        end else begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected", 32'h1, 32'h0);
            end else begin
                mon_e = sbq.pop_front();
                chk("stall_cycles", 32'(scnt), 32'(mon_e.stalls));
                if (mon_e.we) begin
                    chk("st_mem_we", 32'(mem_we), 32'h1);
                    chk("st_mem_a", mem_a, mon_e.addr);
                    chk("st_mem_wd", mem_wd, mon_e.wd);
                    chk("st_memtype", 32'(mem_memtype), 32'(mon_e.mt));
                end else begin
                    chk("ld_rdata", req_rdata, mon_e.rd);
                    chk("ld_mem_we", 32'(mem_we), 32'h0);
                end
            end
            scnt = 0;
        end
        if (done && !drained) begin
            chk("sb_drain", 32'(sbq.size()), 32'h0);
            drained = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic        we, mt;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        for (int i = 0; i < NL; i++) begin rv[i] = 1'b0; rt[i] = '0; end

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue(1'b0, MEMTYPE_WORD, 32'h0001_0000, 32'h0);          // cold miss, DEADBEEF
        issue(1'b0, MEMTYPE_BYTE, 32'h0001_0002, 32'h0);          // hit, 0xAD
        issue(1'b1, MEMTYPE_WORD, 32'h0001_0004, 32'hCAFE_F00D);  // store hit
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0004, 32'h0);
        issue(1'b1, MEMTYPE_BYTE, 32'h0001_0100, 32'h0000_0055);  // store miss, no allocate
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0100, 32'h0);          // miss, 0x00000055
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0000, 32'h0);
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0400, 32'h0);          // conflict eviction
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0000, 32'h0);
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0003, 32'h0);          // misaligned bypass, invalidates index 0
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0000, 32'h0);

        // Abort a refill by reset in its third cycle; nothing is pushed for the aborted load.
        req_valid = 1'b1; req_we = 1'b0; req_memtype = MEMTYPE_WORD; req_addr = 32'h0001_0800;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0; req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < NL; i++) rv[i] = 1'b0;
        @(posedge clk); #1;
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0000, 32'h0);
        issue(1'b0, MEMTYPE_WORD, 32'h0001_0800, 32'h0);

        for (int n = 0; n < 400; n++) begin
            a  = 32'h0001_0000 | (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, NL - 1)) << 4)
                 | 32'($urandom_range(0, 15));
            we = ($urandom_range(0, 99) < 35);
            mt = ($urandom_range(0, 2) == 0);
            if (!mt && $urandom_range(0, 9) != 0) a = a & ~32'd3;
            issue(we, mt, a, $urandom);
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
        end

        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
